// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache refill path.
package cache_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      StIdle,
      StFillRd,
      StFillTag,
      StFillDone,
      StWtWr,
      StWtDone
   } refill_state_t;

   // Width of the word-offset field for a line of n words.
   function automatic int unsigned off_w(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Latency counter and word counter pair for main-memory word beats.
module mem_beat_counter
   import cache_pkg::*;
#(
   parameter int unsigned MEM_LAT        = 3,
   parameter int unsigned WORDS_PER_LINE = 4,
   localparam int unsigned OFF_W         = off_w(WORDS_PER_LINE),
   localparam int unsigned LAT_W         = (MEM_LAT > 1) ? off_w(MEM_LAT) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [OFF_W-1:0] word_cnt,
   output logic             beat_last,
   output logic             word_last
);

   logic [LAT_W-1:0] lat_q;
   logic [OFF_W-1:0] word_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         lat_q  <= '0;
         word_q <= '0;
      end else if (enable) begin
         if (beat_last) begin
            lat_q  <= '0;
            word_q <= word_q + OFF_W'(1);
         end else begin
            lat_q <= lat_q + LAT_W'(1);
         end
      end
   end

   // With MEM_LAT = 1 the latency counter stays at 0 and every beat is last.
   assign beat_last = (lat_q == LAT_W'(MEM_LAT - 1));
   assign word_last = (word_q == OFF_W'(WORDS_PER_LINE - 1));
   assign word_cnt  = word_q;

endmodule

// File: rtl/mem_refill_ctrl.sv
// Main-memory side refill / write-through controller behind the cache FSM.
module mem_refill_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned MEM_LAT        = 3,
   localparam int unsigned OFF_W         = off_w(WORDS_PER_LINE)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    fill_req,
   input  logic                    wt_req,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [DATA_W-1:0]       wt_data,
   input  logic [DATA_W-1:0]       mem_rdata,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   output logic                    mem_re,
   output logic                    mem_we,
   output logic                    cache_we,
   output logic [OFF_W-1:0]        cache_widx,
   output logic [DATA_W-1:0]       cache_wdata,
   output logic [ADDR_W-OFF_W-1:0] line_addr,
   output logic                    tag_we,
   output logic                    fill_done,
   output logic                    wt_done,
   output logic                    busy
);

   refill_state_t     state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [OFF_W-1:0]  word_cnt;
   logic              beat_last;
   logic              word_last;
   logic              cnt_clear;
   logic              cnt_enable;

   // Holding the counters clear in IDLE also clears them on the accepting edge.
   assign cnt_clear  = (state_q == StIdle);
   assign cnt_enable = (state_q == StFillRd) || (state_q == StWtWr);

   mem_beat_counter #(
      .MEM_LAT        (MEM_LAT),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_beat_counter (
      .clk       (clk),
      .reset     (reset),
      .clear     (cnt_clear),
      .enable    (cnt_enable),
      .word_cnt  (word_cnt),
      .beat_last (beat_last),
      .word_last (word_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fill_req || wt_req) begin
                  addr_q  <= req_addr;
                  wdata_q <= wt_data;
                  state_q <= fill_req ? StFillRd : StWtWr;
               end
            end
            StFillRd: begin
               if (beat_last && word_last) state_q <= StFillTag;
            end
            StFillTag:  state_q <= StFillDone;
            StFillDone: state_q <= StIdle;
            StWtWr: begin
               if (beat_last) state_q <= StWtDone;
            end
            StWtDone:   state_q <= StIdle;
            default:    state_q <= StIdle;
         endcase
      end
   end

   assign line_addr   = addr_q[ADDR_W-1:OFF_W];
   assign cache_widx  = word_cnt;
   assign cache_wdata = mem_rdata;
   assign busy        = (state_q != StIdle);

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      cache_we  = 1'b0;
      tag_we    = 1'b0;
      fill_done = 1'b0;
      wt_done   = 1'b0;
      unique case (state_q)
         StFillRd: begin
            mem_re   = 1'b1;
            mem_addr = {addr_q[ADDR_W-1:OFF_W], word_cnt};
            cache_we = beat_last;
         end
         StFillTag:  tag_we = 1'b1;
         StFillDone: fill_done = 1'b1;
         StWtWr: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
         end
         StWtDone:   wt_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Scoreboard bench: stimulus queues expected strobe events, a monitor pops and compares.
module tb_mem_refill_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Unit 0: MEM_LAT = 3; unit 1: MEM_LAT = 1.
   logic        fill_req0, wt_req0, fill_req1, wt_req1;
   logic [7:0]  req_addr0, req_addr1;
   logic [31:0] wt_data0, wt_data1, mem_rdata0, mem_rdata1;
   logic [7:0]  mem_addr0, mem_addr1;
   logic [31:0] mem_wdata0, mem_wdata1, cache_wdata0, cache_wdata1;
   logic        mem_re0, mem_we0, cache_we0, tag_we0, fill_done0, wt_done0, busy0;
   logic        mem_re1, mem_we1, cache_we1, tag_we1, fill_done1, wt_done1, busy1;
   logic [1:0]  cache_widx0, cache_widx1;
   logic [5:0]  line_addr0, line_addr1;

   assign mem_rdata0 = 32'hA0 + {24'b0, mem_addr0};
   assign mem_rdata1 = 32'hA0 + {24'b0, mem_addr1};

   mem_refill_ctrl #(.ADDR_W(8), .DATA_W(32), .WORDS_PER_LINE(4), .MEM_LAT(3)) dut0 (
      .clk(clk), .reset(reset), .fill_req(fill_req0), .wt_req(wt_req0),
      .req_addr(req_addr0), .wt_data(wt_data0), .mem_rdata(mem_rdata0),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_re(mem_re0), .mem_we(mem_we0),
      .cache_we(cache_we0), .cache_widx(cache_widx0), .cache_wdata(cache_wdata0),
      .line_addr(line_addr0), .tag_we(tag_we0), .fill_done(fill_done0),
      .wt_done(wt_done0), .busy(busy0)
   );

   mem_refill_ctrl #(.ADDR_W(8), .DATA_W(32), .WORDS_PER_LINE(4), .MEM_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .fill_req(fill_req1), .wt_req(wt_req1),
      .req_addr(req_addr1), .wt_data(wt_data1), .mem_rdata(mem_rdata1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_re(mem_re1), .mem_we(mem_we1),
      .cache_we(cache_we1), .cache_widx(cache_widx1), .cache_wdata(cache_wdata1),
      .line_addr(line_addr1), .tag_we(tag_we1), .fill_done(fill_done1),
      .wt_done(wt_done1), .busy(busy1)
   );

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];

   function automatic string kname(input int kind);
      case (kind)
         0: return "mem_re";
         1: return "mem_we";
         2: return "cache_we";
         3: return "tag_we";
         4: return "fill_done";
         5: return "wt_done";
         default: return "unknown";
      endcase
   endfunction

   task automatic push(input int unit, input int kind, input int c,
                       input logic [31:0] a, input logic [31:0] d);
      ev_t e;
      e.kind = kind; e.cyc = c; e.a = a; e.d = d;
      if (unit == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Expected fill events; cycle k after the accepting edge sits at cyc base+k.
   task automatic push_fill(input int unit, input int base, input logic [7:0] addr,
                            input int lat, input int kmax);
      int n;
      logic [7:0] a;
      n = 4 * lat;
      for (int k = 1; k <= n && k <= kmax; k++) begin
         a = {addr[7:2], 2'((k - 1) / lat)};
         push(unit, 0, base + k, {24'b0, a}, 32'h0);
         if (k % lat == 0) push(unit, 2, base + k, 32'((k - 1) / lat), 32'hA0 + {24'b0, a});
      end
      if (n + 1 <= kmax) push(unit, 3, base + n + 1, {26'b0, addr[7:2]}, 32'h0);
      if (n + 2 <= kmax) push(unit, 4, base + n + 2, 32'h0, 32'h0);
   endtask

   task automatic push_wt(input int base, input logic [7:0] addr, input logic [31:0] data);
      for (int k = 1; k <= 3; k++) push(0, 1, base + k, {24'b0, addr}, data);
      push(0, 5, base + 4, 32'h0, 32'h0);
   endtask

   task automatic observe(input int unit, input int kind, input logic [31:0] a,
                          input logic [31:0] d);
      ev_t e;
      bit  empty;
      empty = 1'b0;
      checks++;
      if (unit == 0) begin
         if (q0.size() == 0) empty = 1'b1;
         else e = q0.pop_front();
      end else begin
         if (q1.size() == 0) empty = 1'b1;
         else e = q1.pop_front();
      end
      if (empty) begin
         errors++;
         $display("FAIL unexpected_%s unit%0d cyc=%0d: got addr=%h data=%h, required no event",
                  kname(kind), unit, cyc, a, d);
      end else if (e.kind != kind || e.cyc != cyc || e.a != a || e.d != d) begin
         errors++;
         $display("FAIL event unit%0d: got %s cyc=%0d addr=%h data=%h, required %s cyc=%0d addr=%h data=%h",
                  unit, kname(kind), cyc, a, d, kname(e.kind), e.cyc, e.a, e.d);
      end
   endtask

   always @(negedge clk) begin
      if (mem_re0)    observe(0, 0, {24'b0, mem_addr0}, 32'h0);
      if (mem_we0)    observe(0, 1, {24'b0, mem_addr0}, mem_wdata0);
      if (cache_we0)  observe(0, 2, {30'b0, cache_widx0}, cache_wdata0);
      if (tag_we0)    observe(0, 3, {26'b0, line_addr0}, 32'h0);
      if (fill_done0) observe(0, 4, 32'h0, 32'h0);
      if (wt_done0)   observe(0, 5, 32'h0, 32'h0);
      if (mem_re1)    observe(1, 0, {24'b0, mem_addr1}, 32'h0);
      if (mem_we1)    observe(1, 1, {24'b0, mem_addr1}, mem_wdata1);
      if (cache_we1)  observe(1, 2, {30'b0, cache_widx1}, cache_wdata1);
      if (tag_we1)    observe(1, 3, {26'b0, line_addr1}, 32'h0);
      if (fill_done1) observe(1, 4, 32'h0, 32'h0);
      if (wt_done1)   observe(1, 5, 32'h0, 32'h0);
   end

   task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %h, required %h", name, cyc, got, exp);
      end
   endtask

   task automatic check_idle0(input string tag);
      check1({tag, "_busy"}, {31'b0, busy0}, 32'h0);
      check1({tag, "_strobes"},
             {26'b0, mem_re0, mem_we0, cache_we0, tag_we0, fill_done0, wt_done0}, 32'h0);
      check1({tag, "_mem_addr"}, {24'b0, mem_addr0}, 32'h0);
      check1({tag, "_mem_wdata"}, mem_wdata0, 32'h0);
   endtask

   task automatic do_fill(input int unit, input logic [7:0] addr);
      int base, lat;
      lat  = (unit == 0) ? 3 : 1;
      base = cyc;
      if (unit == 0) begin req_addr0 = addr; fill_req0 = 1'b1; end
      else begin req_addr1 = addr; fill_req1 = 1'b1; end
      push_fill(unit, base, addr, lat, 99);
      @(negedge clk);
      check1("fill_busy", {31'b0, (unit == 0) ? busy0 : busy1}, 32'h1);
      repeat (4 * lat + 1) @(negedge clk);
      if (unit == 0) fill_req0 = 1'b0;
      else fill_req1 = 1'b0;
      @(negedge clk);
      check1("fill_idle", {31'b0, (unit == 0) ? busy0 : busy1}, 32'h0);
   endtask

   task automatic do_wt(input logic [7:0] addr, input logic [31:0] data);
      req_addr0 = addr;
      wt_data0  = data;
      wt_req0   = 1'b1;
      push_wt(cyc, addr, data);
      repeat (4) @(negedge clk);
      wt_req0 = 1'b0;
      @(negedge clk);
      check1("wt_idle", {31'b0, busy0}, 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      reset     = 1'b1;
      fill_req0 = 1'b1; wt_req0 = 1'b0; req_addr0 = 8'h2D; wt_data0 = 32'h0;
      fill_req1 = 1'b0; wt_req1 = 1'b0; req_addr1 = 8'h00; wt_data1 = 32'h0;

      // Reset held with fill_req high: nothing may start.
      repeat (3) begin
         @(negedge clk);
         check_idle0("reset");
         check1("reset_line_addr", {26'b0, line_addr0}, 32'h0);
         check1("reset_busy1", {31'b0, busy1}, 32'h0);
      end
      reset = 1'b0;
      do_fill(0, 8'h2D);

      do_wt(8'h40, 32'hDEADBEEF);

      // Simultaneous requests: fill first, write-through once IDLE is re-entered.
      req_addr0 = 8'h21; wt_data0 = 32'h12345678;
      fill_req0 = 1'b1;  wt_req0 = 1'b1;
      base = cyc;
      push_fill(0, base, 8'h21, 3, 99);
      push_wt(base + 15, 8'h21, 32'h12345678);
      repeat (14) @(negedge clk);
      fill_req0 = 1'b0;
      repeat (5) @(negedge clk);
      wt_req0 = 1'b0;
      @(negedge clk);
      check1("both_idle", {31'b0, busy0}, 32'h0);

      // Reset during cycle 7 of a fill.
      req_addr0 = 8'h35; fill_req0 = 1'b1;
      base = cyc;
      push_fill(0, base, 8'h35, 3, 7);
      repeat (7) @(negedge clk);
      reset = 1'b1; fill_req0 = 1'b0;
      @(negedge clk);
      check_idle0("midreset");
      reset = 1'b0;
      @(negedge clk);
      do_fill(0, 8'h10);

      do_fill(1, 8'h04);

      repeat (3) @(negedge clk);
      check1("queue0_drained", q0.size(), 32'h0);
      check1("queue1_drained", q1.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
